morse_decoder: RTL and testbench

MORSE_DECODER -- requirements
Module: morse_decoder

---
 rtl/morse_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_morse_decoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : morse_decoder
//  Description : Decodes a single Morse key into letter codes A=0 .. Z=25.
//                Each key press is timed and classified as a dot or a dash.
//                A long enough key-low interval closes the letter, and the
//                buffered symbol is looked up and handed to a draw stage with
//                a level request/done handshake.
//
//  Ports
//    clk         in   system clock, all logic on rising edge
//    reset       in   synchronous active-high reset
//    key         in   Morse key, active-high, debounced and synchronised
//    draw_done   in   draw stage completion flag, only sampled while requesting
//    draw_req    out  level request to the draw stage
//    letter      out  decoded letter code, held while draw_req is high
//    error       out  one-cycle pulse on an invalid or over-long symbol
//    elem_count  out  number of elements buffered for the current letter
//
//  Revision    : 1.0  initial release
// ============================================================================
module morse_decoder #(
    parameter int DOT_MAX    = 12500000,
    parameter int GAP_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    input  logic       draw_done,
    output logic       draw_req,
    output logic [4:0] letter,
    output logic       error,
    output logic [2:0] elem_count
);

    localparam int              c_GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam logic [25:0]     c_DOT_MAX = 26'(DOT_MAX);
    localparam logic [c_GAP_W-1:0] c_GAP_END = c_GAP_W'(GAP_CYCLES);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_PRESS    = 3'd1;
    localparam logic [2:0] c_S_GAP      = 3'd2;
    localparam logic [2:0] c_S_LOOKUP   = 3'd3;
    localparam logic [2:0] c_S_REQ      = 3'd4;
    localparam logic [2:0] c_S_WAIT_REL = 3'd5;

    logic [2:0]         r_state,      w_state;
    logic [25:0]        r_press_cnt,  w_press_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt,    w_gap_cnt;
    logic [3:0]         r_sym_bits,   w_sym_bits;
    logic [2:0]         r_elem_count, w_elem_count;
    logic [4:0]         r_letter,     w_letter;
    logic               r_draw_req,   w_draw_req;
    logic               r_error,      w_error;

    logic               w_lut_valid;
    logic [4:0]         w_lut_letter;
    logic               w_elem;

    // Element just completed: dash when the press lasted DOT_MAX cycles or more.
    assign w_elem = (r_press_cnt >= c_DOT_MAX);

    // Symbol table. Elements are shifted in MSB-first, so the oldest element
    // sits in the highest valid bit; 0 = dot, 1 = dash. Bits above the
    // element count are don't-care.
    always_comb begin
        w_lut_valid  = 1'b1;
        w_lut_letter = 5'd0;
        casez ({r_elem_count, r_sym_bits})
            7'b001_???0: w_lut_letter = 5'd4;   // E .
            7'b001_???1: w_lut_letter = 5'd19;  // T -
            7'b010_??01: w_lut_letter = 5'd0;   // A .-
            7'b010_??00: w_lut_letter = 5'd8;   // I ..
            7'b010_??11: w_lut_letter = 5'd12;  // M --
            7'b010_??10: w_lut_letter = 5'd13;  // N -.
            7'b011_?000: w_lut_letter = 5'd18;  // S ...
            7'b011_?001: w_lut_letter = 5'd20;  // U ..-
            7'b011_?010: w_lut_letter = 5'd17;  // R .-.
            7'b011_?011: w_lut_letter = 5'd22;  // W .--
            7'b011_?100: w_lut_letter = 5'd3;   // D -..
            7'b011_?101: w_lut_letter = 5'd10;  // K -.-
            7'b011_?110: w_lut_letter = 5'd6;   // G --.
            7'b011_?111: w_lut_letter = 5'd14;  // O ---
            7'b100_1000: w_lut_letter = 5'd1;   // B -...
            7'b100_1010: w_lut_letter = 5'd2;   // C -.-.
            7'b100_0010: w_lut_letter = 5'd5;   // F ..-.
            7'b100_0000: w_lut_letter = 5'd7;   // H ....
            7'b100_0111: w_lut_letter = 5'd9;   // J .---
            7'b100_0100: w_lut_letter = 5'd11;  // L .-..
            7'b100_0110: w_lut_letter = 5'd15;  // P .--.
            7'b100_1101: w_lut_letter = 5'd16;  // Q --.-
            7'b100_0001: w_lut_letter = 5'd21;  // V ...-
            7'b100_1001: w_lut_letter = 5'd23;  // X -..-
            7'b100_1011: w_lut_letter = 5'd24;  // Y -.--
            7'b100_1100: w_lut_letter = 5'd25;  // Z --..
            default:     w_lut_valid  = 1'b0;   // ..--, .-.-, ---., ----
        endcase
    end

    // Next-state and datapath logic.
    always_comb begin
        w_state      = r_state;
        w_press_cnt  = r_press_cnt;
        w_gap_cnt    = r_gap_cnt;
        w_sym_bits   = r_sym_bits;
        w_elem_count = r_elem_count;
        w_letter     = r_letter;
        w_draw_req   = r_draw_req;
        w_error      = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (key) begin
                    w_press_cnt = 26'd1;
                    w_state     = c_S_PRESS;
                end
            end

            c_S_PRESS: begin
                if (key) begin
                    if (!(&r_press_cnt)) begin
                        w_press_cnt = r_press_cnt + 26'd1;
                    end
                end else if (r_elem_count == 3'd4) begin
                    // Fifth element: no letter has that many, drop the symbol.
                    w_error      = 1'b1;
                    w_sym_bits   = 4'd0;
                    w_elem_count = 3'd0;
                    w_state      = c_S_IDLE;
                end else begin
                    w_sym_bits   = {r_sym_bits[2:0], w_elem};
                    w_elem_count = r_elem_count + 3'd1;
                    w_gap_cnt    = '0;
                    w_state      = c_S_GAP;
                end
            end

            c_S_GAP: begin
                // The end-of-letter test wins over a new press so the letter
                // boundary is fixed at exactly GAP_CYCLES counted low cycles.
                if (r_gap_cnt == c_GAP_END) begin
                    w_state = c_S_LOOKUP;
                end else if (key) begin
                    w_press_cnt = 26'd1;
                    w_state     = c_S_PRESS;
                end else begin
                    w_gap_cnt = r_gap_cnt + c_GAP_W'(1);
                end
            end

            c_S_LOOKUP: begin
                w_sym_bits   = 4'd0;
                w_elem_count = 3'd0;
                if (w_lut_valid) begin
                    w_letter   = w_lut_letter;
                    w_draw_req = 1'b1;
                    w_state    = c_S_REQ;
                end else begin
                    w_error = 1'b1;
                    w_state = c_S_IDLE;
                end
            end

            c_S_REQ: begin
                if (draw_done) begin
                    w_draw_req = 1'b0;
                    w_state    = key ? c_S_WAIT_REL : c_S_IDLE;
                end
            end

            c_S_WAIT_REL: begin
                // A press overlapping the draw is discarded in full.
                if (!key) begin
                    w_state = c_S_IDLE;
                end
            end

            default: begin
                w_state = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_press_cnt  <= 26'd0;
            r_gap_cnt    <= '0;
            r_sym_bits   <= 4'd0;
            r_elem_count <= 3'd0;
            r_letter     <= 5'd0;
            r_draw_req   <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_press_cnt  <= w_press_cnt;
            r_gap_cnt    <= w_gap_cnt;
            r_sym_bits   <= w_sym_bits;
            r_elem_count <= w_elem_count;
            r_letter     <= w_letter;
            r_draw_req   <= w_draw_req;
            r_error      <= w_error;
        end
    end

    assign draw_req   = r_draw_req;
    assign letter     = r_letter;
    assign error      = r_error;
    assign elem_count = r_elem_count;

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_morse_decoder
//  Description : Self-checking bench for morse_decoder. Stimulus builds Morse
//                letters from random press/gap durations; a string-based
//                Morse table predicts each draw request or error pulse and
//                its cycle, and a monitor compares DUT events in order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_morse_decoder;

    localparam int DOT = 4;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic       draw_done;
    logic       draw_req;
    logic [4:0] letter;
    logic       error;
    logic [2:0] elem_count;

    always #5 clk = ~clk;

    morse_decoder #(
        .DOT_MAX    (DOT),
        .GAP_CYCLES (GAP)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .key        (key),
        .draw_done  (draw_done),
        .draw_req   (draw_req),
        .letter     (letter),
        .error      (error),
        .elem_count (elem_count)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_err;
        int ltr;
        int at;
    } exp_t;
    exp_t sb[$];

    string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};

    int dur [5];
    int gp  [4];

    function automatic int ref_lookup(string s);
        for (int i = 0; i < 26; i++) begin
            if (morse[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic       prev_req = 1'b0;
    logic [4:0] held     = 5'd0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (error) begin
                chk("error_with_req_rise", int'(draw_req && !prev_req), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_error: got error pulse expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_error", int'(e.is_err), 1);
                    chk("error_cycle", cyc, e.at);
                end
            end
            if (draw_req && !prev_req) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got draw_req letter %0d expected none (cycle %0d)", letter, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_req", int'(e.is_err), 0);
                    chk("letter", int'(letter), e.ltr);
                    chk("req_cycle", cyc, e.at);
                end
                held = letter;
            end else if (draw_req && prev_req) begin
                chk("letter_hold", int'(letter), int'(held));
            end
            prev_req = draw_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(int n);
        key = 1'b1;
        repeat (n) begin
            draw_done = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Key low for g sampled cycles between elements; checks the buffer depth.
    task automatic gap_elem(int g, int exp_cnt);
        key       = 1'b0;
        draw_done = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        chk("elem_count", int'(elem_count), exp_cnt);
        repeat (g - 1) begin
            draw_done = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: normal handshake, mode 1: reset while requesting
    task automatic send_letter(int ne, int hold, bit key_hi, int mode);
        string sym;
        int    idx;
        exp_t  e;
        sym = "";
        for (int i = 0; i < ne; i++) begin
            press(dur[i]);
            if (dur[i] >= DOT) sym = {sym, "-"};
            else               sym = {sym, "."};
            if (i == 4) begin
                e.is_err = 1'b1; e.ltr = 0; e.at = cyc + 1;
                sb.push_back(e);
                key = 1'b0; draw_done = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("elem_count_overflow", int'(elem_count), 0);
                repeat (GAP + 4) @(negedge clk);
                chk("no_req_after_overflow", int'(draw_req), 0);
                return;
            end else if (i < ne - 1) begin
                gap_elem(gp[i], i + 1);
            end
        end
        idx      = ref_lookup(sym);
        e.is_err = (idx < 0);
        e.ltr    = idx;
        e.at     = cyc + 1 + GAP + 2;
        sb.push_back(e);
        key = 1'b0; draw_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("elem_count_last", int'(elem_count), ne);
        while (cyc < e.at) @(negedge clk);
        chk("draw_req_level", int'(draw_req), int'(idx >= 0));
        if (idx < 0) begin
            repeat (GAP + 4) @(negedge clk);
            chk("no_req_after_invalid", int'(draw_req), 0);
            return;
        end
        if (mode == 1) begin
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            chk("rst_req_draw_req", int'(draw_req), 0);
            chk("rst_req_letter", int'(letter), 0);
            chk("rst_req_elem_count", int'(elem_count), 0);
            repeat (2) @(negedge clk);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            key       = 1'($urandom_range(0, 1));
            draw_done = 1'b0;
            @(negedge clk);
            chk("req_held", int'(draw_req), 1);
        end
        key       = key_hi;
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        chk("req_drop", int'(draw_req), 0);
        if (key_hi) begin
            repeat (6) @(negedge clk);
            chk("wait_rel_elem_count", int'(elem_count), 0);
            key = 1'b0;
        end
        repeat (GAP + 4) @(negedge clk);
        chk("idle_after_draw", int'(draw_req), 0);
        chk("idle_elem_count", int'(elem_count), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; key = 1'b0; draw_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_draw_req", int'(draw_req), 0);
        chk("rst_letter", int'(letter), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_elem_count", int'(elem_count), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // E, T (long), T (press of exactly DOT_MAX), R with short gaps
        dur[0] = 2;                          send_letter(1, 3, 1'b0, 0);
        dur[0] = 6;                          send_letter(1, 2, 1'b0, 0);
        dur[0] = 4;                          send_letter(1, 0, 1'b0, 0);
        dur[0] = 1; dur[1] = 6; dur[2] = 2;
        gp[0] = 3;  gp[1] = 3;               send_letter(3, 1, 1'b0, 0);
        // five dots -> overflow error
        for (int i = 0; i < 5; i++) dur[i] = 1;
        for (int i = 0; i < 4; i++) gp[i] = 3;
        send_letter(5, 0, 1'b0, 0);
        // K held 100 cycles with key toggling, key high through draw_done
        dur[0] = 5; dur[1] = 2; dur[2] = 7; gp[0] = 8; gp[1] = 1;
        send_letter(3, 100, 1'b1, 0);
        // ..-- is not a letter
        dur[0] = 1; dur[1] = 3; dur[2] = 5; dur[3] = 4;
        gp[0] = 2; gp[1] = 2; gp[2] = 2;
        send_letter(4, 0, 1'b0, 0);

        // reset mid-press with one dash already buffered
        press(5);
        gap_elem(2, 1);
        press(3);
        reset = 1'b1; key = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_press_elem_count", int'(elem_count), 0);
        chk("rst_press_draw_req", int'(draw_req), 0);
        chk("rst_press_letter", int'(letter), 0);
        dur[0] = 1;                          send_letter(1, 1, 1'b0, 0);
        // reset while requesting, then decode from empty buffer
        dur[0] = 6; dur[1] = 1; gp[0] = 4;   send_letter(2, 0, 1'b0, 1);
        dur[0] = 2; dur[1] = 5; gp[0] = 1;   send_letter(2, 1, 1'b0, 0);
        // reset released with key already high
        reset = 1'b1; key = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        dur[0] = 5;                          send_letter(1, 1, 1'b0, 0);

        // random letters
        for (int n = 0; n < 40; n++) begin
            int ne;
            ne = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4);
            for (int i = 0; i < 5; i++) dur[i] = $urandom_range(1, 7);
            for (int i = 0; i < 4; i++) gp[i]  = $urandom_range(1, GAP);
            send_letter(ne, $urandom_range(0, 10), 1'($urandom_range(0, 1)), 0);
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
